// File: rtl/vga_scanout_if.sv
// vga_scanout_if
//   Framebuffer read port between the VGA scanout engine and the pixel RAM.
//   The scanout side presents a linear pixel address. The RAM returns the
//   addressed 1-bit pixel within two CLOCK_50 cycles.
//
//   Signals:
//     rd_addr [18:0]  pixel index y*H_VISIBLE+x, driven by the scanout (master)
//     rd_data         pixel bit returned by the RAM (slave)
//
//   Modports:
//     master  scanout engine
//     slave   framebuffer RAM read port
interface vga_scanout_if;
   logic [18:0] rd_addr;
   logic        rd_data;

   modport master (output rd_addr, input  rd_data);
   modport slave  (input  rd_addr, output rd_data);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout
//   Read side of the 1-bit framebuffer. Generates 640x480@60 VGA timing from
//   CLOCK_50 using a 25 MHz pixel tick. Walks a linear read address through
//   the visible area and turns each returned pixel bit into 24-bit RGB for
//   the board DAC.
//
//   Ports:
//     CLOCK_50     in   50 MHz system clock
//     reset        in   synchronous, active-high reset
//     fb_rd        if   framebuffer read port (rd_addr out, rd_data in)
//     VGA_R/G/B    out  8-bit colour channels
//     VGA_CLK      out  25 MHz DAC pixel clock
//     VGA_HS       out  horizontal sync, active low
//     VGA_VS       out  vertical sync, active low
//     VGA_BLANK_N  out  low outside the visible region
//     VGA_SYNC_N   out  tied low (no sync-on-green)
//     frame_start  out  one-cycle pulse when the counters wrap to (0,0)
module vga_scanout #(
   parameter int          H_VISIBLE = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_VISIBLE = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter logic [23:0] COLOR_ON  = 24'hFFFFFF
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   vga_scanout_if.master fb_rd,
   output logic [7:0]    VGA_R,
   output logic [7:0]    VGA_G,
   output logic [7:0]    VGA_B,
   output logic          VGA_CLK,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          VGA_BLANK_N,
   output logic          VGA_SYNC_N,
   output logic          frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_VIS_C     = 11'(H_VISIBLE);
   localparam logic [10:0] H_LAST_C    = 11'(H_TOTAL - 1);
   localparam logic [10:0] HS_FIRST_C  = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_LAST_C   = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [10:0] V_VIS_C     = 11'(V_VISIBLE);
   localparam logic [10:0] V_LAST_C    = 11'(V_TOTAL - 1);
   localparam logic [10:0] VS_FIRST_C  = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_LAST_C   = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic [18:0] ADDR_LAST_C = 19'(H_VISIBLE * V_VISIBLE - 1);

   logic        pix_en_q,      pix_en_d;
   logic [10:0] h_cnt_q,       h_cnt_d;
   logic [10:0] v_cnt_q,       v_cnt_d;
   logic [18:0] rd_addr_q,     rd_addr_d;
   logic        blank_n_q,     blank_n_d;
   logic        hs_q,          hs_d;
   logic        vs_q,          vs_d;
   logic [23:0] rgb_q,         rgb_d;
   logic        frame_start_q, frame_start_d;

   logic tick_s;
   logic h_last_s;
   logic v_last_s;
   logic visible_s;
   logic hs_zone_s;
   logic vs_zone_s;

   // Decode the current counter position.
   always_comb begin
      tick_s    = pix_en_q;
      h_last_s  = (h_cnt_q == H_LAST_C);
      v_last_s  = (v_cnt_q == V_LAST_C);
      visible_s = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
      hs_zone_s = (h_cnt_q >= HS_FIRST_C) && (h_cnt_q <= HS_LAST_C);
      vs_zone_s = (v_cnt_q >= VS_FIRST_C) && (v_cnt_q <= VS_LAST_C);
   end

   // Next state of the counters, read address and output stage.
   // The output stage captures the position the counters are leaving, so the
   // pins run one pixel behind the address and the RAM gets a full pixel
   // (two CLOCK_50 cycles) to answer before rd_data is sampled.
   always_comb begin
      pix_en_d      = ~pix_en_q;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      rd_addr_d     = rd_addr_q;
      blank_n_d     = blank_n_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      if (tick_s) begin
         if (h_last_s) begin
            h_cnt_d = 11'd0;
            if (v_last_s) begin
               v_cnt_d = 11'd0;
            end else begin
               v_cnt_d = v_cnt_q + 11'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 11'd1;
            v_cnt_d = v_cnt_q;
         end

         // Running index: advances across visible pixels so that the end of
         // a row lands on the first pixel of the next row, saturates on the
         // last pixel of the frame and rewinds only at the frame wrap.
         if (h_last_s && v_last_s) begin
            rd_addr_d = 19'd0;
         end else if (visible_s && (rd_addr_q != ADDR_LAST_C)) begin
            rd_addr_d = rd_addr_q + 19'd1;
         end else begin
            rd_addr_d = rd_addr_q;
         end

         blank_n_d     = visible_s;
         hs_d          = ~hs_zone_s;
         vs_d          = ~vs_zone_s;
         rgb_d         = (visible_s && fb_rd.rd_data) ? COLOR_ON : 24'h000000;
         frame_start_d = h_last_s && v_last_s;
      end else begin
         frame_start_d = 1'b0;
      end
   end

   // State register with synchronous reset; a mid-frame reset abandons the line.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pix_en_q      <= 1'b0;
         h_cnt_q       <= 11'd0;
         v_cnt_q       <= 11'd0;
         rd_addr_q     <= 19'd0;
         blank_n_q     <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         rgb_q         <= 24'h000000;
         frame_start_q <= 1'b0;
      end else begin
         pix_en_q      <= pix_en_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         rd_addr_q     <= rd_addr_d;
         blank_n_q     <= blank_n_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign fb_rd.rd_addr = rd_addr_q;
   assign VGA_R         = rgb_q[23:16];
   assign VGA_G         = rgb_q[15:8];
   assign VGA_B         = rgb_q[7:0];
   assign VGA_CLK       = pix_en_q;
   assign VGA_HS        = hs_q;
   assign VGA_VS        = vs_q;
   assign VGA_BLANK_N   = blank_n_q;
   assign VGA_SYNC_N    = 1'b0;
   assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
//   Bench for vga_scanout. A reduced-timing instance (16x11 total, 8x6
//   visible) is compared every cycle against a position model derived from
//   the elapsed cycle count. A full-size 640x480 instance runs alongside to
//   pin the real line timing with literal cycle counts.
module tb_vga_scanout;

   localparam int SH_VIS = 8,  SH_FP = 2, SH_SYNC = 3, SH_BP = 3;
   localparam int SV_VIS = 6,  SV_FP = 1, SV_SYNC = 2, SV_BP = 2;
   localparam int SH_TOT = SH_VIS + SH_FP + SH_SYNC + SH_BP;   // 16
   localparam int SV_TOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;   // 11
   localparam int FRAME  = SH_TOT * SV_TOT;                    // 176 pixels
   localparam int NPIX   = SH_VIS * SV_VIS;                    // 48
   localparam int AMAX   = NPIX - 1;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int k      = 0;   // edges since the small DUT left reset
   int bk     = 0;   // same for the full-size DUT

   logic sreset, breset;
   logic chk_en = 1'b0;
   logic lat2, noise_en, noise_bit;
   bit   mem [0:NPIX-1];

   // Small DUT
   vga_scanout_if sif();
   logic [7:0] s_r, s_g, s_b;
   logic s_clk, s_hs, s_vs, s_blank_n, s_sync_n, s_fs;

   vga_scanout #(
      .H_VISIBLE(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
      .V_VISIBLE(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
      .COLOR_ON(24'hFFFFFF)
   ) u_small (
      .CLOCK_50(clk), .reset(sreset), .fb_rd(sif),
      .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_CLK(s_clk),
      .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_blank_n),
      .VGA_SYNC_N(s_sync_n), .frame_start(s_fs)
   );

   // Full-size DUT
   vga_scanout_if bif();
   logic [7:0] b_r, b_g, b_b;
   logic b_clk, b_hs, b_vs, b_blank_n, b_sync_n, b_fs;

   vga_scanout u_big (
      .CLOCK_50(clk), .reset(breset), .fb_rd(bif),
      .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_CLK(b_clk),
      .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_blank_n),
      .VGA_SYNC_N(b_sync_n), .frame_start(b_fs)
   );

   assign bif.rd_data = bif.rd_addr[0];

   // ---------------- framebuffer RAM model (small DUT) ----------------
   // lat2=1: registered read, data ready two edges after the address launch.
   // lat2=0: asynchronous read. With noise_en, rd_data is random whenever a
   // correct scanout must ignore it (non-tick cycles, blanked positions).
   logic ram_q;
   always @(posedge clk) ram_q <= (sif.rd_addr < 19'(NPIX)) ? mem[sif.rd_addr] : 1'b0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) k   <= sreset ? 0 : k + 1;
   always @(posedge clk) bk  <= breset ? 0 : bk + 1;
   always @(negedge clk) noise_bit <= 1'($urandom & 1);

   function automatic bit vis(input int h, input int v);
      return (h < SH_VIS) && (v < SV_VIS);
   endfunction

   always_comb begin
      logic ram_out;
      int   p;
      ram_out = lat2 ? ram_q : ((sif.rd_addr < 19'(NPIX)) ? mem[sif.rd_addr] : 1'b0);
      p = (k / 2) % FRAME;
      if (noise_en && ((k % 2 == 0) || !vis(p % SH_TOT, p / SH_TOT)))
         sif.rd_data = noise_bit;
      else
         sif.rd_data = ram_out;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (k=%0d bk=%0d)", name, act, exp, k, bk);
      end
   endtask

   // Address expected while the counters sit at pixel position kk/2 of the frame.
   function automatic int exp_addr(input int kk);
      int p, h, v;
      p = (kk / 2) % FRAME;
      h = p % SH_TOT;
      v = p / SH_TOT;
      if (vis(h, v)) return v * SH_VIS + h;
      else if (v < SV_VIS) return ((v + 1) * SH_VIS > AMAX) ? AMAX : (v + 1) * SH_VIS;
      else return AMAX;
   endfunction

   // ---------------- per-cycle model comparison (small DUT) ----------------
   always @(negedge clk) begin : cmp
      int t, q, h, v;
      logic e_blank, e_hs, e_vs, e_fs;
      logic [23:0] e_rgb;
      if (chk_en) begin
         t = k / 2;
         chk("vga_clk", 32'(s_clk), 32'(k % 2));
         chk("rd_addr", 32'(sif.rd_addr), 32'(exp_addr(k)));
         chk("sync_n", 32'(s_sync_n), 32'd0);
         if (t == 0) begin
            e_blank = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 24'h0;
         end else begin
            q = (t - 1) % FRAME;
            h = q % SH_TOT;
            v = q / SH_TOT;
            e_blank = vis(h, v);
            e_hs    = !(h >= SH_VIS + SH_FP && h < SH_VIS + SH_FP + SH_SYNC);
            e_vs    = !(v >= SV_VIS + SV_FP && v < SV_VIS + SV_FP + SV_SYNC);
            e_rgb   = (e_blank && mem[v * SH_VIS + h]) ? 24'hFFFFFF : 24'h0;
            e_fs    = (k % 2 == 0) && (t % FRAME == 0);
         end
         chk("blank_n", 32'(s_blank_n), 32'(e_blank));
         chk("hs", 32'(s_hs), 32'(e_hs));
         chk("vs", 32'(s_vs), 32'(e_vs));
         chk("rgb", 32'({s_r, s_g, s_b}), 32'(e_rgb));
         chk("frame_start", 32'(s_fs), 32'(e_fs));
      end
   end

   // ---------------- literal timing measurements (small DUT) ----------------
   int  hs_fall, blank_rise, vs_fall, fs_rise, rst_cyc, lines;
   bit  hs_v, br_v, br_off_v, vs_v, fs_v, rst_v;
   logic p_hs = 1'b1, p_blank = 1'b0, p_vs = 1'b1, p_fs = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         if (k == 0) begin
            hs_v = 0; br_v = 0; br_off_v = 0; vs_v = 0; fs_v = 0;
            rst_v = 1; rst_cyc = cyc; lines = 0;
         end else begin
            if (p_hs && !s_hs) begin
               if (hs_v) chk("hs_period", 32'(cyc - hs_fall), 32'd32);
               if (br_off_v) chk("hs_fall_offset", 32'(cyc - blank_rise), 32'd20);
               br_off_v = 0; hs_v = 1; hs_fall = cyc;
            end
            if (!p_hs && s_hs && hs_v) chk("hs_low", 32'(cyc - hs_fall), 32'd6);
            if (!p_blank && s_blank_n) begin
               br_v = 1; br_off_v = 1; blank_rise = cyc; lines++;
            end
            if (p_blank && !s_blank_n && br_v) chk("blank_high", 32'(cyc - blank_rise), 32'd16);
            if (p_vs && !s_vs) begin
               if (vs_v) chk("vs_period", 32'(cyc - vs_fall), 32'd352);
               vs_v = 1; vs_fall = cyc;
            end
            if (!p_vs && s_vs && vs_v) chk("vs_low", 32'(cyc - vs_fall), 32'd64);
            if (!p_fs && s_fs) begin
               if (fs_v) begin
                  chk("fs_period", 32'(cyc - fs_rise), 32'd352);
                  chk("lines_per_frame", 32'(lines), 32'd6);
               end
               if (rst_v) chk("fs_after_reset", 32'(cyc - rst_cyc), 32'd352);
               rst_v = 0; fs_v = 1; fs_rise = cyc; lines = 0;
            end
            if (p_fs && !s_fs && fs_v) chk("fs_width", 32'(cyc - fs_rise), 32'd1);
         end
         p_hs = s_hs; p_blank = s_blank_n; p_vs = s_vs; p_fs = s_fs;
      end
   end

   // ---------------- literal checks on the full-size DUT ----------------
   int  bhs_fall, bbl_rise;
   bit  bhs_v, bbl_v, bbl_off_v;
   logic bp_hs = 1'b1, bp_blank = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         if (bk == 0) begin
            bhs_v = 0; bbl_v = 0; bbl_off_v = 0;
         end else begin
            if (bk == 2) begin
               chk("big_first_blank", 32'(b_blank_n), 32'd1);
               chk("big_first_rgb", 32'({b_r, b_g, b_b}), 32'h000000);
            end
            if (bk == 4) chk("big_second_rgb", 32'({b_r, b_g, b_b}), 32'hFFFFFF);
            if (bk == 1278) chk("big_addr_639_0", 32'(bif.rd_addr), 32'd639);
            if (bk == 1600) chk("big_addr_0_1", 32'(bif.rd_addr), 32'd640);
            if (bp_hs && !b_hs) begin
               if (bhs_v) chk("big_hs_period", 32'(cyc - bhs_fall), 32'd1600);
               if (bbl_off_v) chk("big_hs_offset", 32'(cyc - bbl_rise), 32'd1312);
               bbl_off_v = 0; bhs_v = 1; bhs_fall = cyc;
            end
            if (!bp_hs && b_hs && bhs_v) chk("big_hs_low", 32'(cyc - bhs_fall), 32'd192);
            if (!bp_blank && b_blank_n) begin
               bbl_v = 1; bbl_off_v = 1; bbl_rise = cyc;
            end
            if (bp_blank && !b_blank_n && bbl_v) chk("big_blank_high", 32'(cyc - bbl_rise), 32'd1280);
         end
         bp_hs = b_hs; bp_blank = b_blank_n;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_k(input int target);
      int guard;
      guard = 0;
      while (k < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (k != target) begin
         errors++;
         $display("FAIL wait_k: got %0d expected %0d", k, target);
      end
   endtask

   task automatic hold_reset(input int n);
      sreset = 1'b1;
      repeat (n) @(negedge clk);
      sreset = 1'b0;
   endtask

   initial begin
      sreset = 1'b1; breset = 1'b1; lat2 = 1'b1; noise_en = 1'b0;
      for (int i = 0; i < NPIX; i++) mem[i] = 1'(i & 1);
      @(negedge clk);
      chk_en = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_hs", 32'(s_hs), 32'd1);
      chk("rst_vs", 32'(s_vs), 32'd1);
      chk("rst_blank", 32'(s_blank_n), 32'd0);
      chk("rst_rgb", 32'({s_r, s_g, s_b}), 32'd0);
      chk("rst_addr", 32'(sif.rd_addr), 32'd0);
      chk("rst_sync_n", 32'(s_sync_n), 32'd0);
      chk("rst_vga_clk", 32'(s_clk), 32'd0);
      sreset = 1'b0; breset = 1'b0;

      // First tick lands on the second edge after release.
      @(negedge clk);
      chk("edge1_clk", 32'(s_clk), 32'd1);
      chk("edge1_addr", 32'(sif.rd_addr), 32'd0);
      @(negedge clk);
      chk("edge2_addr", 32'(sif.rd_addr), 32'd1);
      chk("edge2_rgb", 32'({s_r, s_g, s_b}), 32'h000000);
      chk("edge2_blank", 32'(s_blank_n), 32'd1);
      wait_k(4);
      chk("edge4_rgb", 32'({s_r, s_g, s_b}), 32'hFFFFFF);
      wait_k(2 * 7);
      chk("addr_7_0", 32'(sif.rd_addr), 32'd7);
      wait_k(2 * 16);
      chk("addr_0_1", 32'(sif.rd_addr), 32'd8);
      wait_k(2 * (5 * 16 + 7));
      chk("addr_last", 32'(sif.rd_addr), 32'd47);
      wait_k(2 * (10 * 16 + 15));
      chk("addr_held", 32'(sif.rd_addr), 32'd47);
      wait_k(2 * FRAME);
      chk("addr_wrap", 32'(sif.rd_addr), 32'd0);
      chk("fs_at_wrap", 32'(s_fs), 32'd1);
      wait_k(4 * FRAME + 10);

      // Same pattern through an asynchronous-read RAM: output must match.
      sreset = 1'b1;
      lat2 = 1'b0;
      repeat (3) @(negedge clk);
      sreset = 1'b0;
      wait_k(2);
      chk("lat1_rgb_first", 32'({s_r, s_g, s_b}), 32'h000000);
      wait_k(4);
      chk("lat1_rgb_second", 32'({s_r, s_g, s_b}), 32'hFFFFFF);
      wait_k(2 * FRAME + 20);

      // Random image, random latency, garbage on ignored rd_data cycles.
      sreset = 1'b1;
      for (int i = 0; i < NPIX; i++) mem[i] = 1'($urandom & 1);
      lat2 = 1'($urandom & 1);
      noise_en = 1'b1;
      repeat (2) @(negedge clk);
      sreset = 1'b0;
      wait_k(2 * (FRAME + 3 * 16 + 5));
      hold_reset(1);
      chk("midrst_addr", 32'(sif.rd_addr), 32'd0);
      chk("midrst_blank", 32'(s_blank_n), 32'd0);
      chk("midrst_hs", 32'(s_hs), 32'd1);
      chk("midrst_rgb", 32'({s_r, s_g, s_b}), 32'd0);
      wait_k(2 * FRAME);
      chk("midrst_addr_restart", 32'(sif.rd_addr), 32'd0);
      lat2 = lat2;
      wait_k(4 * FRAME + 30);

      // Let the full-size instance finish three lines.
      while (cyc < 5300) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read side of the 1-bit pixel framebuffer.
- Generates 640x480@60 Hz VGA timing from CLOCK_50 with a 25 MHz pixel tick.
- Issues a linear read address to the framebuffer RAM read port and maps the returned pixel bit to 24-bit RGB.
- Drives the board VGA DAC pins. The pixel-writing side (line drawer / clear logic) stays on the RAM write port.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HS pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- COLOR_ON, 24'hFFFFFF, RGB driven for pixel bit 1 (bit 0 gives 24'h000000)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- rd_addr  out  19  framebuffer read address, y*640+x
- rd_data  in  1  framebuffer pixel bit, valid within 2 CLOCK_50 cycles of rd_addr
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- VGA_CLK  out  1  25 MHz DAC pixel clock
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  low outside the visible region
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
- frame_start  out  1  one-CLOCK_50 pulse at frame wrap

Behaviour:
- Reset state: pix_en=0, h_cnt=0, v_cnt=0, rd_addr=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, VGA_CLK=0, frame_start=0.
- Reset mid-frame returns everything to these values on the next edge. No partial-line completion.
- Pixel tick:
  - pix_en toggles every CLOCK_50 cycle; tick = (pix_en==1).
  - The first tick occurs on the 2nd edge after reset deasserts.
  - VGA_CLK = pix_en register. Its rising edge falls mid-pixel relative to output updates.
- Counters, advanced on tick only:
  - h_cnt runs 0..H_TOTAL-1 (800) and wraps to 0.
  - On h wrap, v_cnt runs 0..V_TOTAL-1 (525) and wraps to 0.
  - Totals are the sums of the parameters. Counter widths are 11 bits.
- Address:
  - rd_addr is a running index, not a multiplier.
  - On a tick while (h_cnt<640 && v_cnt<480) it increments.
  - On a tick that wraps both counters it is set to 0. Otherwise it holds.
  - While the counters sit at visible (h,v), rd_addr = v*640+h.
  - Maximum value 307199. After that it holds through blanking until the frame wrap.
- Output stage:
  - All outputs update only on tick.
  - They reflect the counter state of the previous tick, i.e. one pixel (2 CLOCK_50 cycles) behind the counters. This gives the RAM its 2-cycle latency.
  - VGA_BLANK_N = registered (h<640 && v<480).
  - VGA_HS low iff h in [656,751]. VGA_VS low iff v in [490,491].
  - RGB = COLOR_ON if (blank_n_delayed && rd_data) else 0. rd_data is sampled on the same tick edge.
- frame_start: high for exactly one CLOCK_50 cycle, on the edge where the tick moves the counters from (799,524) to (0,0).
- rd_data is ignored outside the visible region.
- No backpressure and no handshake. The RAM read port is free-running.

Test Plan:
- Reset: hold reset 5 cycles → HS=VS=1, BLANK_N=0, RGB=0, rd_addr=0, VGA_SYNC_N=0. Release → first tick on 2nd edge; VGA_CLK toggles every cycle.
- Line timing: run 1 line → HS period 1600 CLOCK_50 cycles, HS low 192 cycles, BLANK_N high 1280 cycles per line, HS falling edge 1312 cycles after BLANK_N rising.
- Frame timing: run 2 frames → VS period 840000 cycles, VS low 3200 cycles, frame_start period 840000 with a width of 1 cycle, 480 BLANK_N-high lines per frame.
- Address sequence: log rd_addr → 0 at (0,0), 639 at (639,0), 640 at (0,1), 307199 at (639,479); held through blanking; 0 after frame_start.
- Data alignment: RAM model with 2-cycle latency, pixel = addr[0] → RGB alternates FFFFFF/000000 starting with 000000 at the first BLANK_N-high pixel. Repeat with a 1-cycle-latency model → identical output.
- Reset mid-frame: assert reset at (h=300,v=200) for 1 cycle → next edge shows reset values. After release, the next frame_start occurs 840000 cycles later and rd_addr restarts at 0.
